// File: rtl/uart_txd.sv
`default_nettype none
// ============================================================================
// Module   : uart_txd
// Brief    : UART transmitter, 8N1 (LSB first) with a one-byte holding
//            register so back-to-back frames leave no idle gap.
//            Optional even-parity bit enabled by macro UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_txd #(
  parameter int BAUD           = 115200,
  parameter int SYS_CLK_PERIOD = 50
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_ready,
  output logic       Txd,
  output logic       tx_busy,
  output logic       tx_done
);

  // Cycles per bit; shared with the receiver so both ends agree on timing.
  localparam int          BAUD_CNT_END = 1_000_000_000 / BAUD / SYS_CLK_PERIOD;
  localparam logic [15:0] c_CNT_LAST   = 16'(BAUD_CNT_END - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_cnt_next;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [7:0]  r_hold;
  logic        r_tx_ready;
  logic        r_txd;
  logic        w_txd_next;
  logic        r_busy;
  logic        r_done;
  logic        w_done_next;
  logic        w_transfer;
  logic        w_accept;
  logic        w_hold_full;
  logic        w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  // tx_ready low means the holding register holds a byte not yet shifted.
  assign w_hold_full = ~r_tx_ready;
  assign w_accept    = tx_req & r_tx_ready;
  assign w_bit_end   = (r_state != S_IDLE) && (r_baud_cnt == c_CNT_LAST);

  // Next-state, shift, counter and line-level decode.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_done_next    = 1'b0;
    w_transfer     = 1'b0;
    w_txd_next     = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_hold_full) begin
          w_transfer     = 1'b1;
          w_state_next   = S_START;
          w_shift_next   = r_hold;
          w_bit_cnt_next = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_done_next = 1'b1;
          // A queued byte starts immediately so the line never idles between frames.
          if (w_hold_full) begin
            w_transfer     = 1'b1;
            w_state_next   = S_START;
            w_shift_next   = r_hold;
            w_bit_cnt_next = 3'd0;
          end else begin
            w_state_next   = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Counter is pinned at zero in IDLE so the first bit gets a full period.
    if ((r_state == S_IDLE) || w_bit_end) w_baud_cnt_next = 16'd0;
    else                                  w_baud_cnt_next = r_baud_cnt + 16'd1;

    // Line level is decoded from the next state so Txd can be a flop.
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_next = r_parity;
`endif
      default:  w_txd_next = 1'b1;
    endcase
  end

  // FSM state, baud/bit counters and shift register.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
    end
  end

  // Holding register: load on acceptance, release to the shifter on transfer.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold     <= 8'd0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_hold     <= tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_transfer) begin
        r_tx_ready <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte being shifted, captured when it leaves the holding register.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N)          r_parity <= 1'b0;
    else if (w_transfer) r_parity <= ^r_hold;
  end
`endif

  // Registered line and status outputs.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_txd  <= w_txd_next;
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_done_next;
    end
  end

  assign tx_ready = r_tx_ready;
  assign Txd      = r_txd;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_txd.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_txd
// Brief    : Directed self-checking bench for uart_txd (honours
//            UART_TX_PARITY_EN for the frame length and parity bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_txd;

  localparam int BIT = 173;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = BIT * NB;

  logic       SYS_CLK;
  logic       RST_N;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ready;
  logic       Txd;
  logic       tx_busy;
  logic       tx_done;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  uart_txd dut (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_ready (tx_ready),
    .Txd      (Txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial SYS_CLK = 1'b0;
  always #25 SYS_CLK = ~SYS_CLK;

  // Edge counter: after posedge n (and until the next one) cyc == n.
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge SYS_CLK);
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Send one byte with a single-cycle request; start = edge where the frame begins.
  task automatic send(input logic [7:0] d, output int start);
    int n;
    n = 0;
    @(negedge SYS_CLK);
    while (!tx_ready && n < 4000) begin
      @(negedge SYS_CLK);
      n++;
    end
    chk("send_ready_wait", (n < 4000), 1'b1);
    tx_data = d;
    tx_req  = 1'b1;
    @(posedge SYS_CLK);
    #1;
    tx_req  = 1'b0;
    start   = cyc + 1;
  endtask

  // Check first and last cycle of every bit, busy, and the tx_done pulse.
  task automatic check_frame(input logic [7:0] d, input int start);
    for (int b = 0; b < NB; b++) begin
      if (cyc <= start + BIT * b) begin
        wait_until(start + BIT * b);
        chk($sformatf("txd_first d=%h b%0d", d, b), Txd, exp_bit(d, b));
        chk($sformatf("busy_first d=%h b%0d", d, b), tx_busy, 1'b1);
      end
      wait_until(start + BIT * b + BIT - 1);
      chk($sformatf("txd_last d=%h b%0d", d, b), Txd, exp_bit(d, b));
      chk($sformatf("busy_last d=%h b%0d", d, b), tx_busy, 1'b1);
    end
    chk($sformatf("done_early d=%h", d), tx_done, 1'b0);
    wait_until(start + FRAME);
    chk($sformatf("done_pulse d=%h", d), tx_done, 1'b1);
  endtask

  initial begin
    int s;
    int s0;
    bit timeout6;
    RST_N   = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge SYS_CLK);
    chk("rst_txd", Txd, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge SYS_CLK);

    // 1: single 0x55 frame, exact latency and busy width
    send(8'h55, s);
    chk("t1_busy_at_accept", tx_busy, 1'b0);
    chk("t1_ready_at_accept", tx_ready, 1'b0);
    check_frame(8'h55, s);
    chk("t1_busy_cleared", tx_busy, 1'b0);
    chk("t1_ready_back", tx_ready, 1'b1);
    wait_until(s + FRAME + 1);
    chk("t1_done_single", tx_done, 1'b0);
    chk("t1_idle_line", Txd, 1'b1);

    // 2: back-to-back 0xA5, 0x3C with no gap
    send(8'hA5, s);
    send(8'h3C, s0);
    check_frame(8'hA5, s);
    check_frame(8'h3C, s + FRAME);
    chk("t2_busy_cleared", tx_busy, 1'b0);
    wait_until(s + 2 * FRAME + 1);
    chk("t2_done_off", tx_done, 1'b0);

    // 3: third request while holding register is full is ignored
    send(8'h11, s);
    send(8'h22, s0);
    tx_data = 8'h33;
    tx_req  = 1'b1;
    repeat (3) begin
      @(negedge SYS_CLK);
      chk("t3_ready_blocked", tx_ready, 1'b0);
    end
    tx_req = 1'b0;
    check_frame(8'h11, s);
    check_frame(8'h22, s + FRAME);
    wait_until(s + 2 * FRAME + 200);
    chk("t3_no_third_txd", Txd, 1'b1);
    chk("t3_no_third_busy", tx_busy, 1'b0);
    chk("t3_ready", tx_ready, 1'b1);

    // 4: reset in the middle of a 0xF0 frame, then a clean 0x0F frame
    send(8'hF0, s);
    wait_until(s + 499);
    chk("t4_pre_rst_txd", Txd, 1'b0);
    chk("t4_pre_rst_busy", tx_busy, 1'b1);
    #5 RST_N = 1'b0;
    #1;
    chk("t4_rst_txd", Txd, 1'b1);
    chk("t4_rst_busy", tx_busy, 1'b0);
    chk("t4_rst_ready", tx_ready, 1'b1);
    repeat (2) @(negedge SYS_CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    chk("t4_post_rst_txd", Txd, 1'b1);
    send(8'h0F, s);
    check_frame(8'h0F, s);
    chk("t4_busy_cleared", tx_busy, 1'b0);

    // 5: parity-sensitive bytes (odd and even popcount)
    send(8'h07, s);
    check_frame(8'h07, s);
    send(8'h03, s);
    check_frame(8'h03, s);

    // 6: tx_req held high, data 0x00..0x04 -> five contiguous frames
    timeout6 = 1'b0;
    @(negedge SYS_CLK);
    tx_data = 8'h00;
    tx_req  = 1'b1;
    @(posedge SYS_CLK);
    #1;
    s0 = cyc + 1;
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          int n;
          tx_data = 8'(i);
          n = 0;
          @(negedge SYS_CLK);
          while (!tx_ready && n < 4000) begin
            @(negedge SYS_CLK);
            n++;
          end
          if (n >= 4000) timeout6 = 1'b1;
          @(posedge SYS_CLK);
          #1;
        end
        tx_req = 1'b0;
      end
      begin
        for (int j = 0; j < 5; j++) check_frame(8'(j), s0 + FRAME * j);
      end
    join
    chk("t6_no_timeout", timeout6, 1'b0);
    wait_until(s0 + 5 * FRAME + 5);
    chk("t6_busy_cleared", tx_busy, 1'b0);
    chk("t6_line_idle", Txd, 1'b1);
    chk("t6_ready", tx_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_txd.md
Name: uart_txd

Overview:
UART transmitter, 8N1 by default, LSB first. It is the transmit end of the board's serial link and is timed identically to the existing UART receiver, with the same baud and clock constants. A one-byte holding register lets upstream logic queue the next byte while the current frame shifts out. This gives gap-free back-to-back frames for the UART-to-SDRAM return path.

Parameters:
BAUD, 115200, line rate in bit/s.
SYS_CLK_PERIOD, 50, system clock period in ns (20 MHz).
BAUD_CNT_END, 1_000_000_000/BAUD/SYS_CLK_PERIOD (=173), clock cycles per bit, derived and not overridden.

Ports:
SYS_CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous, active-low reset.
tx_data  in  8  byte to send; sampled when tx_req && tx_ready.
tx_req  in  1  request; a byte is accepted on any rising edge where tx_req=1 and tx_ready=1.
tx_ready  out  1  registered; 1 = holding register empty.
Txd  out  1  serial line, registered, idles high.
tx_busy  out  1  registered; 1 while a frame is on the line (start through stop).
tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (asynchronous, immediate): Txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, holding register empty.
- Reset asserted mid-frame aborts the frame: Txd returns high at once. After release the block is in IDLE and ready; no partial frame resumes.
- Holding register:
  - Loads tx_data on acceptance and clears tx_ready on the same edge.
  - Moves into the shift register when the FSM is in IDLE, or on the last cycle of a stop bit; that move sets tx_ready=1.
  - Acceptance (needs empty) and transfer (needs full) are mutually exclusive in a cycle.
  - tx_req while tx_ready=0 is ignored; tx_data is not sampled.
- Baud counter:
  - 16-bit, counts 0..BAUD_CNT_END-1 while state != IDLE, then wraps.
  - Held at 0 in IDLE.
  - Every bit lasts exactly BAUD_CNT_END cycles; bit_end = (count == BAUD_CNT_END-1).
- FSM states: IDLE, START, DATA, STOP (PARITY when the optional feature is compiled in).
  - IDLE -> START: when the holding register is full.
  - START -> DATA: on bit_end. Txd=0 throughout START.
  - DATA: Txd = shift[0]. On each bit_end the register shifts right and the 3-bit bit counter increments. After the bit_end with counter=7, go to STOP (or PARITY).
  - STOP: Txd=1. On bit_end: pulse tx_done; go to START if the holding register is full (no idle gap), else go to IDLE.
- Latency: byte accepted at edge k; state=START and Txd=0 from edge k+1. A full frame occupies 10*BAUD_CNT_END = 1730 cycles.
- tx_busy: set on entry to START, cleared on entry to IDLE. It stays 1 across back-to-back frames.
- tx_done and tx_ready=1 from a transfer may coincide.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting one bit period. It drives the even-parity bit (XOR of the 8 data bits), and the frame grows to 11 bit periods.
- Undefined: no PARITY state and no parity logic; the frame is 8N1, 10 bit periods.

Test Plan:
1. Reset, then tx_data=0x55 with tx_req held 1 cycle -> Txd low from the next edge. Line carries 0,1,0,1,0,1,0,1,0,1, each 173 cycles. tx_done pulses at cycle 1730 after start; tx_busy=1 for exactly 1730 cycles.
2. Send 0xA5, then 0x3C as soon as tx_ready returns high -> two frames with no high gap between stop and start. Total 3460 cycles, 2 tx_done pulses, tx_busy continuously 1.
3. Send 0x11, 0x22, then 0x33 while tx_ready=0 -> 0x33 is ignored. Only 0x11 and 0x22 appear on Txd.
4. Assert RST_N low at cycle 500 of a 0xF0 frame -> Txd=1, tx_busy=0, tx_ready=1 immediately. After release, sending 0x0F yields a clean, full 0x0F frame.
5. With UART_TX_PARITY_EN defined: 0x07 -> parity bit 1, and 0x03 -> parity bit 0. Frame length 1903 cycles; tx_done at the end of the stop bit.
6. tx_req held high continuously with incrementing data 0x00..0x04 -> five contiguous frames in order. Each byte is accepted exactly once.
